fpu_addsub_scheduler: RTL and testbench

Issue controller for the single-precision add/sub pipeline. Arbitrates round-robin between two requesters, drives the operands into stage 1, and generates per-stage enables for the `Stages`-deep datapath. Tracks per-stage valid, tag and port bits, and returns results through a valid/ready handshake with global backpressure. Sits between the FPU front-end ports and the stage chain beginning at `PipelinedStage1`.

---
 rtl/fpu_addsub_scheduler_pkg.sv | 12 +
 rtl/fpu_addsub_scheduler_if.sv | 57 +++++
 rtl/fpu_addsub_scheduler_rr_arbiter2.sv | 36 +++
 rtl/fpu_addsub_scheduler.sv | 109 ++++++++++
 tb/tb_fpu_addsub_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_addsub_scheduler_pkg.sv
// Shared FPU constants: operand/tag widths and the add/sub operation encoding.
package fpu_pkg;

    localparam int FPU_DATA_SIZE = 32;
    localparam int FPU_TAG_SIZE  = 4;

    localparam logic FPU_OP_ADD = 1'b0;
    localparam logic FPU_OP_SUB = 1'b1;

    typedef logic [FPU_TAG_SIZE-1:0] fpu_tag_t;

endpackage

// File: rtl/fpu_addsub_scheduler_if.sv
// Request, issue and result bundle between the FPU front-end, the scheduler and the stage chain.
interface fpu_addsub_scheduler_if
    import fpu_pkg::*;
#(
    parameter int DATA_SIZE = FPU_DATA_SIZE,
    parameter int TAG_SIZE  = FPU_TAG_SIZE,
    parameter int STAGES    = 4
);

    logic                         req0_valid;
    logic                         req0_ready;
    logic [DATA_SIZE-1:0]         req0_operand1;
    logic [DATA_SIZE-1:0]         req0_operand2;
    logic                         req0_operation;
    logic [TAG_SIZE-1:0]          req0_tag;

    logic                         req1_valid;
    logic                         req1_ready;
    logic [DATA_SIZE-1:0]         req1_operand1;
    logic [DATA_SIZE-1:0]         req1_operand2;
    logic                         req1_operation;
    logic [TAG_SIZE-1:0]          req1_tag;

    logic [DATA_SIZE-1:0]         issue_operand1;
    logic [DATA_SIZE-1:0]         issue_operand2;
    logic                         issue_operation;
    logic [STAGES-1:0]            stage_enable;
    logic [DATA_SIZE-1:0]         pipe_result;

    logic                         res_valid;
    logic                         res_ready;
    logic [DATA_SIZE-1:0]         res_data;
    logic [TAG_SIZE-1:0]          res_tag;
    logic                         res_port;

    logic [$clog2(STAGES+1)-1:0]  in_flight;
    logic                         busy;

    modport master (
        output req0_valid, req0_operand1, req0_operand2, req0_operation, req0_tag,
        output req1_valid, req1_operand1, req1_operand2, req1_operation, req1_tag,
        output pipe_result, res_ready,
        input  req0_ready, req1_ready,
        input  issue_operand1, issue_operand2, issue_operation, stage_enable,
        input  res_valid, res_data, res_tag, res_port, in_flight, busy
    );

    modport slave (
        input  req0_valid, req0_operand1, req0_operand2, req0_operation, req0_tag,
        input  req1_valid, req1_operand1, req1_operand2, req1_operation, req1_tag,
        input  pipe_result, res_ready,
        output req0_ready, req1_ready,
        output issue_operand1, issue_operand2, issue_operation, stage_enable,
        output res_valid, res_data, res_tag, res_port, in_flight, busy
    );

endinterface

// File: rtl/fpu_addsub_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer only moves when a request is actually accepted.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant,
    output logic ready0,
    output logic ready1
);

    logic rr;

    // Pointer picks only under contention; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = rr;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

    assign ready0 = advance && !grant && valid0;
    assign ready1 = advance &&  grant && valid1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr <= 1'b0;
        end else if (ready0 || ready1) begin
            rr <= !grant;
        end
    end

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// Issue controller for the add/sub pipeline: arbitration, stage enables, per-stage valid/tag/port tracking.
// Optional FPU_SCHED_FLUSH_EN adds a flush input that empties the pipe while keeping the arbiter pointer.
module fpu_addsub_scheduler
    import fpu_pkg::*;
#(
    parameter int DATA_SIZE = FPU_DATA_SIZE,
    parameter int TAG_SIZE  = FPU_TAG_SIZE,
    parameter int STAGES    = 4
) (
    input logic clk,
    input logic reset,
`ifdef FPU_SCHED_FLUSH_EN
    input logic flush,
`endif
    fpu_addsub_scheduler_if.slave bus
);

    localparam int CNT_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]   v;
    logic [STAGES-1:0]   p;
    logic [TAG_SIZE-1:0] t [STAGES];
    logic [CNT_W-1:0]    in_flight;

    logic flush_now;
    logic advance;
    logic issue_ok;
    logic grant;
    logic ready0;
    logic ready1;
    logic accept;
    logic res_valid;
    logic res_fire;

`ifdef FPU_SCHED_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Whole pipe moves in lockstep; only a held result at the tail can stall it.
    assign advance  = !v[STAGES-1] || bus.res_ready;
    assign issue_ok = advance && reset && !flush_now;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .advance(issue_ok),
        .grant  (grant),
        .ready0 (ready0),
        .ready1 (ready1)
    );

    assign accept    = ready0 || ready1;
    assign res_valid = v[STAGES-1] && reset && !flush_now;
    assign res_fire  = res_valid && bus.res_ready;

    always_comb begin
        bus.issue_operand1  = bus.req0_operand1;
        bus.issue_operand2  = bus.req0_operand2;
        bus.issue_operation = bus.req0_operation;
        if (grant) begin
            bus.issue_operand1  = bus.req1_operand1;
            bus.issue_operand2  = bus.req1_operand2;
            bus.issue_operation = bus.req1_operation;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v         <= '0;
            p         <= '0;
            in_flight <= '0;
            for (int i = 0; i < STAGES; i++) begin
                t[i] <= '0;
            end
        end else if (flush_now) begin
            v         <= '0;
            in_flight <= '0;
        end else begin
            if (advance) begin
                v    <= {v[STAGES-2:0], accept};
                p    <= {p[STAGES-2:0], grant};
                t[0] <= grant ? bus.req1_tag : bus.req0_tag;
                for (int i = 1; i < STAGES; i++) begin
                    t[i] <= t[i-1];
                end
            end
            case ({accept, res_fire})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.stage_enable = {STAGES{advance}};
    assign bus.res_valid    = res_valid;
    assign bus.res_data     = bus.pipe_result;
    assign bus.res_tag      = t[STAGES-1];
    assign bus.res_port     = p[STAGES-1];
    assign bus.in_flight    = in_flight;
    assign bus.busy         = (in_flight != '0);

endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// Scoreboard bench for fpu_addsub_scheduler with a table-driven stand-in for the datapath stages.
module tb_fpu_addsub_scheduler;
    import fpu_pkg::*;

    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        port;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
`ifdef FPU_SCHED_FLUSH_EN
    logic flush;
`endif
    int   vectors_applied = 0;
    int   miscompares = 0;
    int   cycle = 0;
    bit   check_latency = 1'b0;
    exp_t sb[$];
    logic [31:0] pipe [STAGES];

    fpu_addsub_scheduler_if #(.DATA_SIZE(32), .TAG_SIZE(4), .STAGES(STAGES)) bus ();

    fpu_addsub_scheduler #(.DATA_SIZE(32), .TAG_SIZE(4), .STAGES(STAGES)) dut (
        .clk  (clk),
        .reset(reset),
`ifdef FPU_SCHED_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Datapath stand-in: known float sums from a table, an arbitrary mix otherwise.
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (op == FPU_OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == FPU_OP_SUB && a == 32'h40000000 && b == 32'h3F800000) return 32'h3F800000;
        if (op == FPU_OP_ADD && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        return a ^ {b[15:0], b[31:16]} ^ {31'd0, op};
    endfunction

    always @(posedge clk) begin
        if (bus.stage_enable[0]) begin
            pipe[0] <= fmodel(bus.issue_operand1, bus.issue_operand2, bus.issue_operation);
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.pipe_result = pipe[STAGES-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("res_data", bus.res_data, e.data);
                checkOutput("res_tag", bus.res_tag, e.tag);
                checkOutput("res_port", bus.res_port, e.port);
                if (check_latency) checkOutput("latency", cycle - e.cycle, STAGES);
            end
        end
        if (bus.req0_valid && bus.req0_ready)
            sb.push_back('{fmodel(bus.req0_operand1, bus.req0_operand2, bus.req0_operation),
                           bus.req0_tag, 1'b0, cycle});
        if (bus.req1_valid && bus.req1_ready)
            sb.push_back('{fmodel(bus.req1_operand1, bus.req1_operand2, bus.req1_operation),
                           bus.req1_tag, 1'b1, cycle});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic op, input logic [3:0] tag);
        if (port == 0) begin
            bus.req0_valid = valid; bus.req0_operand1 = a; bus.req0_operand2 = b;
            bus.req0_operation = op; bus.req0_tag = tag;
        end else begin
            bus.req1_valid = valid; bus.req1_operand1 = a; bus.req1_operand2 = b;
            bus.req1_operation = op; bus.req1_tag = tag;
        end
    endtask

    task automatic doReset;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic waitResValid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.res_valid) return;
        end
        checkOutput("timeout_res_valid", 64'd0, 64'd1);
    endtask

    task automatic waitEmpty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        checkOutput("timeout_drain", sb.size(), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
`ifdef FPU_SCHED_FLUSH_EN
        flush = 1'b0;
`endif
        bus.res_ready = 1'b1;
        applyStimulus(0, 1'b1, 32'h0, 32'h0, FPU_OP_ADD, 4'd0);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, FPU_OP_ADD, 4'd0);
        repeat (2) tick();
        @(negedge clk);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_in_flight", bus.in_flight, 0);
        checkOutput("rst_ready0", bus.req0_ready, 0);
        tick();
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        tick();

        // Single operation, 1.0 + 2.0 from port 0
        check_latency = 1'b1;
        applyStimulus(0, 1'b1, 32'h3F800000, 32'h40000000, FPU_OP_ADD, 4'd3);
        @(negedge clk);
        checkOutput("single_ready0", bus.req0_ready, 1);
        checkOutput("single_in_flight0", bus.in_flight, 0);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        checkOutput("single_in_flight1", bus.in_flight, 1);
        waitResValid(10);
        checkOutput("single_data", bus.res_data, 32'h40400000);
        checkOutput("single_tag", bus.res_tag, 4'd3);
        tick();
        @(negedge clk);
        checkOutput("single_in_flight_end", bus.in_flight, 0);
        tick();

        // Contention: both ports valid for 6 cycles
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1'b1, 32'h1000 + k, 32'h7 * k, FPU_OP_ADD, 4'(k));
            applyStimulus(1, 1'b1, 32'h2000 + k, 32'h5 * k, FPU_OP_SUB, 4'(8 + k));
            @(negedge clk);
            checkOutput($sformatf("cont_grant%0d", k), {bus.req1_ready, bus.req0_ready},
                        (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("cont_in_flight%0d", k), bus.in_flight, (k < 4) ? k : 4);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        waitEmpty(20);
        tick();

        // Backpressure: fill the pipe with the result side stalled
        check_latency = 1'b0;
        bus.res_ready = 1'b0;
        applyStimulus(0, 1'b1, 32'h40000000, 32'h3F800000, FPU_OP_SUB, 4'd1);
        applyStimulus(1, 1'b1, 32'h40000000, 32'h40000000, FPU_OP_ADD, 4'd2);
        waitResValid(12);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                tick();
                @(negedge clk);
            end
            checkOutput("bp_ready0", bus.req0_ready, 0);
            checkOutput("bp_ready1", bus.req1_ready, 0);
            checkOutput("bp_stage_enable", bus.stage_enable, 0);
            checkOutput("bp_in_flight", bus.in_flight, 4);
            if (sb.size() != 0) begin
                checkOutput("bp_data_hold", bus.res_data, sb[0].data);
                checkOutput("bp_tag_hold", bus.res_tag, sb[0].tag);
            end else begin
                checkOutput("bp_sb_nonempty", 64'd0, 64'd1);
            end
        end
        tick();
        bus.res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_accept", bus.req0_ready | bus.req1_ready, 1);
        checkOutput("bp_release_valid", bus.res_valid, 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            @(negedge clk);
            checkOutput($sformatf("bp_drain_valid%0d", j), bus.res_valid, 1);
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        waitEmpty(20);
        tick();

        // Reset with two port-0 ops in flight (pointer then points at port 1)
        applyStimulus(0, 1'b1, 32'h11, 32'h22, FPU_OP_ADD, 4'd5);
        tick();
        applyStimulus(0, 1'b1, 32'h33, 32'h44, FPU_OP_SUB, 4'd6);
        tick();
        doReset();
        for (int j = 0; j < STAGES + 2; j++) begin
            @(negedge clk);
            checkOutput("rst_mid_no_result", bus.res_valid, 0);
            checkOutput("rst_mid_in_flight", bus.in_flight, 0);
            tick();
        end
        applyStimulus(0, 1'b1, 32'h55, 32'h66, FPU_OP_ADD, 4'd7);
        applyStimulus(1, 1'b1, 32'h77, 32'h88, FPU_OP_ADD, 4'd9);
        @(negedge clk);
        checkOutput("rst_mid_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        waitEmpty(20);
        tick();

`ifdef FPU_SCHED_FLUSH_EN
        // Flush with three ops in flight, timed to a valid result
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b1, 32'h900 + k, 32'h1, FPU_OP_ADD, 4'(k));
            applyStimulus(1, 1'b1, 32'hA00 + k, 32'h2, FPU_OP_SUB, 4'(4 + k));
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int j = 0; j < 10 && !bus.res_valid; j++) tick();
        checkOutput("flush_precond_valid", bus.res_valid, 1);
        flush = 1'b1;
        bus.req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("flush_res_valid", bus.res_valid, 0);
        checkOutput("flush_ready0", bus.req0_ready, 0);
        tick();
        flush = 1'b0;
        bus.req0_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("flush_busy", bus.busy, 0);
        checkOutput("flush_in_flight", bus.in_flight, 0);
        tick();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("flush_rr_kept", {bus.req1_ready, bus.req0_ready}, 2'b10);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        waitEmpty(20);
        tick();
`endif

        checkOutput("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
